// File: rtl/axi_lite_write_master.sv
// AXI4-Lite write initiator: turns one LSU store into a single AW/W beat pair,
// waits for the B response and reports OK, bus error or misalignment to the core.
module axi_lite_write_master #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_err,
   output logic              resp_misalign,
   output logic [1:0]        resp_code,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEND   = 2'd1;
   localparam logic [1:0] WAIT_B = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0] state;
   logic       aw_done;
   logic       w_done;
   logic       accept;
   logic       illegal;
   logic [3:0] base_mask;
   logic [1:0] off;
   logic       aw_hs;
   logic       w_hs;
   logic       aw_fin;
   logic       w_fin;

   assign req_ready  = (state == IDLE);
   assign bready     = (state == WAIT_B);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;
   assign off        = req_addr[1:0];
   assign aw_hs      = awvalid && awready;
   assign w_hs       = wvalid && wready;
   assign aw_fin     = aw_done || aw_hs;
   assign w_fin      = w_done || w_hs;

   // Lane mask and legality of the incoming request; size 11 is reserved.
   always_comb begin
      illegal   = 1'b0;
      base_mask = 4'b0000;
      case (req_size)
         2'b00: base_mask = 4'b0001;
         2'b01: begin
            base_mask = 4'b0011;
            illegal   = req_addr[0];
         end
         2'b10: begin
            base_mask = 4'b1111;
            illegal   = (off != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         awaddr        <= '0;
         awvalid       <= 1'b0;
         wdata         <= '0;
         wstrb         <= '0;
         wvalid        <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         resp_err      <= 1'b0;
         resp_misalign <= 1'b0;
         resp_code     <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     state         <= RESP;
                     resp_err      <= 1'b1;
                     resp_misalign <= 1'b1;
                     resp_code     <= 2'b00;
                  end else begin
                     state   <= SEND;
                     awaddr  <= req_addr;
                     wdata   <= req_data << {off, 3'b000};
                     wstrb   <= base_mask << off;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                  end
               end
            end
            // The two channels complete independently; leave only once both have.
            SEND: begin
               if (aw_hs) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  state <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (bvalid) begin
                  resp_code     <= bresp;
                  resp_err      <= (bresp != 2'b00);
                  resp_misalign <= 1'b0;
                  state         <= RESP;
               end
            end
            default: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Scoreboard bench for axi_lite_write_master: stimulus pushes expected beats and
// completions, a negedge monitor plays the AXI slave and checks what the DUT presents.
module tb_axi_lite_write_master;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } bus_exp_t;

   typedef struct {
      logic       err;
      logic       mis;
      logic [1:0] code;
      int         lat;
      int         acc;
   } resp_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_size = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic        resp_err;
   logic        resp_misalign;
   logic [1:0]  resp_code;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready = 1'b0;
   logic [1:0]  bresp = 2'b00;
   logic        bvalid = 1'b0;
   logic        bready;

   bus_exp_t  bus_q[$];
   resp_exp_t resp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic mon_en = 1'b0;
   int aw_lat = 0;
   int w_lat = 0;
   int resp_lat = 0;
   logic [1:0] b_val = 2'b00;
   int aw_beats = 0;
   int w_beats = 0;
   int completions = 0;
   int last_resp_cycles = 0;

   axi_lite_write_master #(.ADDR_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .req_data(req_data),
      .req_size(req_size),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_err(resp_err),
      .resp_misalign(resp_misalign),
      .resp_code(resp_code),
      .awaddr(awaddr),
      .awvalid(awvalid),
      .awready(awready),
      .wdata(wdata),
      .wstrb(wstrb),
      .wvalid(wvalid),
      .wready(wready),
      .bresp(bresp),
      .bvalid(bvalid),
      .bready(bready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] strbMask(input logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) m[8*i +: 8] = 8'hFF;
      end
      return m;
   endfunction

   // Slave model and monitor: decides this cycle's ready/valid responses and
   // records the handshakes that will fire on the coming rising edge.
   logic aw_fire = 1'b0, w_fire = 1'b0, b_fire = 1'b0;
   logic got_aw = 1'b0, got_w = 1'b0, both_done = 1'b0, resp_first = 1'b1;
   int aw_cnt = 0, w_cnt = 0, resp_cnt = 0;
   bus_exp_t  bus_tmp;
   resp_exp_t resp_tmp;

   always @(negedge clk) begin
      if (!mon_en) begin
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; resp_ready = 1'b0;
         aw_cnt = 0; w_cnt = 0; resp_cnt = 0;
         aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0;
         got_aw = 1'b0; got_w = 1'b0; both_done = 1'b0; resp_first = 1'b1;
      end else begin
         if (b_fire) begin
            bvalid = 1'b0; bresp = 2'b00; b_fire = 1'b0; both_done = 1'b0;
         end
         if (aw_fire) begin
            got_aw = 1'b1; aw_fire = 1'b0; awready = 1'b0; aw_cnt = 0;
         end
         if (w_fire) begin
            got_w = 1'b1; w_fire = 1'b0; wready = 1'b0; w_cnt = 0;
         end
         if (got_aw && got_w) begin
            got_aw = 1'b0; got_w = 1'b0; both_done = 1'b1;
            bvalid = 1'b1; bresp = b_val;
            if (bus_q.size() != 0) bus_tmp = bus_q.pop_front();
         end
         if (bready) begin
            checkOutput("bready_after_both", 32'(both_done), 32'd1);
            if (bvalid) b_fire = 1'b1;
         end

         if (awvalid) begin
            checkOutput("aw_expected", 32'(bus_q.size() != 0), 32'd1);
            if (bus_q.size() != 0) checkOutput("awaddr", awaddr, bus_q[0].addr);
            awready = (aw_cnt >= aw_lat);
            aw_cnt++;
            if (awready) begin
               aw_fire = 1'b1;
               aw_beats++;
            end
         end else begin
            awready = 1'b0;
            aw_cnt = 0;
         end

         if (wvalid) begin
            checkOutput("w_expected", 32'(bus_q.size() != 0), 32'd1);
            if (bus_q.size() != 0) begin
               checkOutput("wstrb", 32'(wstrb), 32'(bus_q[0].strb));
               checkOutput("wdata", wdata & strbMask(bus_q[0].strb),
                           bus_q[0].data & strbMask(bus_q[0].strb));
            end
            wready = (w_cnt >= w_lat);
            w_cnt++;
            if (wready) begin
               w_fire = 1'b1;
               w_beats++;
            end
         end else begin
            wready = 1'b0;
            w_cnt = 0;
         end

         if (resp_valid) begin
            checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
            checkOutput("resp_expected", 32'(resp_q.size() != 0), 32'd1);
            if (resp_q.size() != 0) begin
               checkOutput("resp_err", 32'(resp_err), 32'(resp_q[0].err));
               checkOutput("resp_misalign", 32'(resp_misalign), 32'(resp_q[0].mis));
               checkOutput("resp_code", 32'(resp_code), 32'(resp_q[0].code));
               if (resp_first && resp_q[0].lat >= 0)
                  checkOutput("resp_latency", 32'(cyc - resp_q[0].acc), 32'(resp_q[0].lat));
            end
            resp_first = 1'b0;
            resp_ready = (resp_cnt >= resp_lat);
            resp_cnt++;
            if (resp_ready) begin
               if (resp_q.size() != 0) resp_tmp = resp_q.pop_front();
               completions++;
               last_resp_cycles = resp_cnt;
               resp_cnt = 0;
               resp_first = 1'b1;
            end
         end else begin
            resp_ready = 1'b0;
            resp_cnt = 0;
         end
      end
   end

   // Issue one store, queue its expectations and wait for its single completion.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                                input logic [3:0] exp_strb, input logic [31:0] exp_data,
                                input logic exp_err, input logic exp_mis, input logic [1:0] exp_code,
                                input int exp_lat);
      int n;
      int done0;
      int aw0;
      int w0;
      bus_exp_t  be;
      resp_exp_t re;
      done0 = completions;
      aw0 = aw_beats;
      w0 = w_beats;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("req_ready_before_issue", 32'(req_ready), 32'd1);
      req_addr = addr;
      req_data = data;
      req_size = size;
      req_valid = 1'b1;
      if (!exp_mis) begin
         be.addr = addr; be.strb = exp_strb; be.data = exp_data;
         bus_q.push_back(be);
      end
      re.err = exp_err; re.mis = exp_mis; re.code = exp_code; re.lat = exp_lat; re.acc = cyc;
      resp_q.push_back(re);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (completions == done0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checkOutput("completion_count", 32'(completions - done0), 32'd1);
      checkOutput("aw_beats", 32'(aw_beats - aw0), exp_mis ? 32'd0 : 32'd1);
      checkOutput("w_beats", 32'(w_beats - w0), exp_mis ? 32'd0 : 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int done0;
      bus_exp_t be;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_awvalid", 32'(awvalid), 32'd0);
      checkOutput("rst_wvalid", 32'(wvalid), 32'd0);
      checkOutput("rst_bready", 32'(bready), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_fields", {28'd0, resp_err, resp_misalign, resp_code}, 32'd0);
      checkOutput("rst_awaddr", awaddr, 32'd0);
      checkOutput("rst_wdata", wdata, 32'd0);
      checkOutput("rst_wstrb", 32'(wstrb), 32'd0);
      mon_en = 1'b1;
      @(negedge clk);

      $display("[TB] word, byte and half stores against a zero-wait slave");
      applyStimulus(32'h1000_0000, 32'hDEAD_BEEF, 2'b10, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 3);
      applyStimulus(32'hA000_03F9, 32'h0000_0041, 2'b00, 4'b0010, 32'h0000_4100, 1'b0, 1'b0, 2'b00, 3);
      applyStimulus(32'h2000_0002, 32'h0000_1234, 2'b01, 4'b1100, 32'h1234_0000, 1'b0, 1'b0, 2'b00, 3);
      applyStimulus(32'h2000_0003, 32'h0000_00A5, 2'b00, 4'b1000, 32'hA500_0000, 1'b0, 1'b0, 2'b00, 3);

      $display("[TB] W handshake three cycles ahead of AW");
      w_lat = 2;
      aw_lat = 5;
      applyStimulus(32'h3000_0004, 32'hCAFE_F00D, 2'b10, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 2'b00, -1);
      w_lat = 4;
      aw_lat = 0;
      applyStimulus(32'h3000_0010, 32'h0000_5AA5, 2'b01, 4'b0011, 32'h0000_5AA5, 1'b0, 1'b0, 2'b00, -1);
      w_lat = 0;

      $display("[TB] SLVERR with a slow core");
      b_val = 2'b10;
      resp_lat = 4;
      applyStimulus(32'h4000_0008, 32'h1122_3344, 2'b10, 4'b1111, 32'h1122_3344, 1'b1, 1'b0, 2'b10, 3);
      checkOutput("resp_hold_cycles", 32'(last_resp_cycles), 32'd5);
      b_val = 2'b00;
      resp_lat = 0;

      $display("[TB] misaligned and reserved-size requests");
      applyStimulus(32'h5000_0002, 32'h0BAD_0BAD, 2'b10, 4'b0000, 32'h0, 1'b1, 1'b1, 2'b00, 1);
      applyStimulus(32'h5000_0000, 32'h0BAD_0BAD, 2'b11, 4'b0000, 32'h0, 1'b1, 1'b1, 2'b00, 1);
      applyStimulus(32'h5000_0001, 32'h0000_BEEF, 2'b01, 4'b0000, 32'h0, 1'b1, 1'b1, 2'b00, 1);

      $display("[TB] reset while in SEND");
      aw_lat = 20;
      w_lat = 20;
      done0 = completions;
      be.addr = 32'h6000_0000; be.strb = 4'b1111; be.data = 32'h7777_8888;
      bus_q.push_back(be);
      req_addr = 32'h6000_0000;
      req_data = 32'h7777_8888;
      req_size = 2'b10;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("awvalid_before_rst", 32'(awvalid), 32'd1);
      rst = 1'b1;
      mon_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_awvalid", 32'(awvalid), 32'd0);
      checkOutput("midrst_wvalid", 32'(wvalid), 32'd0);
      checkOutput("midrst_bready", 32'(bready), 32'd0);
      checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
      bus_q.delete();
      resp_q.delete();
      repeat (3) @(negedge clk);
      checkOutput("midrst_still_no_resp", 32'(resp_valid), 32'd0);
      checkOutput("midrst_no_completion", 32'(completions - done0), 32'd0);
      aw_lat = 0;
      w_lat = 0;
      mon_en = 1'b1;
      @(negedge clk);

      $display("[TB] recovery store after reset");
      applyStimulus(32'h7000_0001, 32'h0000_00C3, 2'b00, 4'b0010, 32'h0000_C300, 1'b0, 1'b0, 2'b00, 3);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
